// File: rtl/vtc_pkg.sv
// Shared constants for the video timing counters: default widths and the decoded
// terminal-count values for the main and phase counters.
package vtc_pkg;

  localparam int CW_DEF = 10;
  localparam int PW_DEF = 8;

  localparam int CNT_K10  = 10;
  localparam int CNT_K13  = 13;
  localparam int CNT_K21  = 21;
  localparam int CNT_K44  = 44;
  localparam int CNT_K45  = 45;
  localparam int CNT_K261 = 261;
  localparam int CNT_K272 = 272;
  localparam int CNT_K283 = 283;
  localparam int CNT_K284 = 284;
  localparam int CNT_K509 = 509;
  localparam int CNT_K511 = 511;
  localparam int CNT_K567 = 567;
  localparam int CNT_K591 = 591;

  localparam int PCNT_K6   = 6;
  localparam int PCNT_K12  = 12;
  localparam int PCNT_K17  = 17;
  localparam int PCNT_K27  = 27;
  localparam int PCNT_K241 = 241;

  localparam int NCNT_K  = 13;
  localparam int NPCNT_K = 5;

endpackage

// File: rtl/vtc_counter.sv
// Clear > enable > hold counter with registered equality flags; the optional wrap
// pulse is present only when VTC_WRAP_FLAG_EN is defined.
module vtc_counter #(
  parameter int            W     = 10,
  parameter int            NK    = 1,
  parameter logic [NK*W-1:0] KVALS = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [W-1:0]  q,
  output logic [NK-1:0] hit
`ifdef VTC_WRAP_FLAG_EN
  ,
  output logic          wrap
`endif
);

  logic [W-1:0]  nxt;
  logic [NK-1:0] hit_d;

  always_comb begin
    nxt = q;
    if (clr)
      nxt = '0;
    else if (en)
      nxt = q + 1'b1;
  end

  // Flags decode the next value so they line up with the register holding it.
  always_comb begin
    hit_d = '0;
    for (int i = 0; i < NK; i++)
      hit_d[i] = (nxt == KVALS[i*W +: W]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= '0;
      hit <= '0;
    end else begin
      q   <= nxt;
      hit <= hit_d;
    end
  end

`ifdef VTC_WRAP_FLAG_EN
  // Only a genuine increment from all-ones counts as a wrap; clears never pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wrap <= 1'b0;
    else
      wrap <= !clr && en && (q == '1);
  end
`endif

endmodule

// File: rtl/video_timing_counters.sv
// Main and phase timing counters with registered terminal-count flags for the sync
// controller. Defining VTC_WRAP_FLAG_EN adds cnt_wrap/pcnt_wrap pulses.
module video_timing_counters
  import vtc_pkg::*;
#(
  parameter int CW = CW_DEF,
  parameter int PW = PW_DEF
) (
  input  logic          CK,
  input  logic          RN,
  input  logic          cclr,
  input  logic          csm,
  input  logic          pclr,
  input  logic          pc,
  output logic [CW-1:0] cnt_q,
  output logic [PW-1:0] pcnt_q,
  output logic          cnt10,
  output logic          cnt13,
  output logic          cnt21,
  output logic          cnt44,
  output logic          cnt45,
  output logic          cnt261,
  output logic          cnt272,
  output logic          cnt283,
  output logic          cnt284,
  output logic          cnt509,
  output logic          cnt511,
  output logic          cnt567,
  output logic          cnt591,
  output logic          pcnt6,
  output logic          pcnt12,
  output logic          pcnt17,
  output logic          pcnt27,
  output logic          pcnt241
`ifdef VTC_WRAP_FLAG_EN
  ,
  output logic          cnt_wrap,
  output logic          pcnt_wrap
`endif
);

  localparam logic [NCNT_K*CW-1:0] CNT_KS = {
    CW'(CNT_K591), CW'(CNT_K567), CW'(CNT_K511), CW'(CNT_K509),
    CW'(CNT_K284), CW'(CNT_K283), CW'(CNT_K272), CW'(CNT_K261),
    CW'(CNT_K45),  CW'(CNT_K44),  CW'(CNT_K21),  CW'(CNT_K13),
    CW'(CNT_K10)
  };

  localparam logic [NPCNT_K*PW-1:0] PCNT_KS = {
    PW'(PCNT_K241), PW'(PCNT_K27), PW'(PCNT_K17), PW'(PCNT_K12), PW'(PCNT_K6)
  };

  logic [NCNT_K-1:0]  cnt_hit;
  logic [NPCNT_K-1:0] pcnt_hit;

  // The main counter free-runs unless stalled; the phase counter only steps on pc.
  vtc_counter #(.W(CW), .NK(NCNT_K), .KVALS(CNT_KS)) u_main (
    .clk   (CK),
    .rst_n (RN),
    .clr   (cclr),
    .en    (~csm),
    .q     (cnt_q),
    .hit   (cnt_hit)
`ifdef VTC_WRAP_FLAG_EN
    ,
    .wrap  (cnt_wrap)
`endif
  );

  vtc_counter #(.W(PW), .NK(NPCNT_K), .KVALS(PCNT_KS)) u_phase (
    .clk   (CK),
    .rst_n (RN),
    .clr   (pclr),
    .en    (pc),
    .q     (pcnt_q),
    .hit   (pcnt_hit)
`ifdef VTC_WRAP_FLAG_EN
    ,
    .wrap  (pcnt_wrap)
`endif
  );

  assign {cnt591, cnt567, cnt511, cnt509, cnt284, cnt283, cnt272, cnt261,
          cnt45, cnt44, cnt21, cnt13, cnt10} = cnt_hit;

  assign {pcnt241, pcnt27, pcnt17, pcnt12, pcnt6} = pcnt_hit;

endmodule

// File: tb/tb_video_timing_counters.sv
// Self-checking bench for video_timing_counters: hand sequences for reset, sweep,
// stall and clear priority, then a vector table for the phase counter.
module tb_video_timing_counters;

  logic       CK = 1'b0;
  logic       RN;
  logic       cclr, csm, pclr, pc;
  logic [9:0] cnt_q;
  logic [7:0] pcnt_q;
  logic cnt10, cnt13, cnt21, cnt44, cnt45, cnt261, cnt272, cnt283, cnt284;
  logic cnt509, cnt511, cnt567, cnt591;
  logic pcnt6, pcnt12, pcnt17, pcnt27, pcnt241;
`ifdef VTC_WRAP_FLAG_EN
  logic cnt_wrap, pcnt_wrap;
`endif

  int total = 0;
  int bad   = 0;
  int step  = 0;
  int ec    = 0;
  int ep    = 0;

  typedef struct {
    bit cclr, csm, pclr, pc;
    int exp_cnt, exp_pcnt;
    bit exp_cw, exp_pw;
  } vec_t;

  vec_t vecs[$];

  video_timing_counters dut (
    .CK(CK), .RN(RN), .cclr(cclr), .csm(csm), .pclr(pclr), .pc(pc),
    .cnt_q(cnt_q), .pcnt_q(pcnt_q),
    .cnt10(cnt10), .cnt13(cnt13), .cnt21(cnt21), .cnt44(cnt44), .cnt45(cnt45),
    .cnt261(cnt261), .cnt272(cnt272), .cnt283(cnt283), .cnt284(cnt284),
    .cnt509(cnt509), .cnt511(cnt511), .cnt567(cnt567), .cnt591(cnt591),
    .pcnt6(pcnt6), .pcnt12(pcnt12), .pcnt17(pcnt17), .pcnt27(pcnt27),
    .pcnt241(pcnt241)
`ifdef VTC_WRAP_FLAG_EN
    ,
    .cnt_wrap(cnt_wrap), .pcnt_wrap(pcnt_wrap)
`endif
  );

  always #5 CK = ~CK;

  function automatic logic [12:0] cntDecode(int v);
    logic [12:0] r;
    r = '0;
    case (v)
      10:  r[0]  = 1'b1;
      13:  r[1]  = 1'b1;
      21:  r[2]  = 1'b1;
      44:  r[3]  = 1'b1;
      45:  r[4]  = 1'b1;
      261: r[5]  = 1'b1;
      272: r[6]  = 1'b1;
      283: r[7]  = 1'b1;
      284: r[8]  = 1'b1;
      509: r[9]  = 1'b1;
      511: r[10] = 1'b1;
      567: r[11] = 1'b1;
      591: r[12] = 1'b1;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [4:0] pcntDecode(int v);
    logic [4:0] r;
    r = '0;
    case (v)
      6:   r[0] = 1'b1;
      12:  r[1] = 1'b1;
      17:  r[2] = 1'b1;
      27:  r[3] = 1'b1;
      241: r[4] = 1'b1;
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic checkOne(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s at step %0d: got %0d want %0d", name, step, act, exp);
    end
  endtask

  task automatic checkOutput(input int exp_cnt, input int exp_pcnt,
                             input bit exp_cw, input bit exp_pw);
    logic [12:0] cf;
    logic [4:0]  pf;
    cf = {cnt591, cnt567, cnt511, cnt509, cnt284, cnt283, cnt272, cnt261,
          cnt45, cnt44, cnt21, cnt13, cnt10};
    pf = {pcnt241, pcnt27, pcnt17, pcnt12, pcnt6};
    checkOne("cnt_q", int'(cnt_q), exp_cnt);
    checkOne("pcnt_q", int'(pcnt_q), exp_pcnt);
    checkOne("cnt_flags", int'(cf), int'(cntDecode(exp_cnt)));
    checkOne("pcnt_flags", int'(pf), int'(pcntDecode(exp_pcnt)));
`ifdef VTC_WRAP_FLAG_EN
    checkOne("cnt_wrap", int'(cnt_wrap), int'(exp_cw));
    checkOne("pcnt_wrap", int'(pcnt_wrap), int'(exp_pw));
`else
    if (exp_cw || exp_pw) step = step;
`endif
  endtask

  // Drive inputs just after an edge, then sample 1 time unit after the next edge.
  task automatic applyStimulus(input bit c_clr, input bit c_sm, input bit p_clr, input bit p_c);
    cclr = c_clr;
    csm  = c_sm;
    pclr = p_clr;
    pc   = p_c;
    @(posedge CK);
    #1;
    step++;
  endtask

  task automatic runFree(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(0, 0, 0, 0);
      ec = (ec + 1) % 1024;
      checkOutput(ec, ep, ec == 0, 1'b0);
    end
  endtask

  task automatic pushVec(input bit a, input bit b, input bit c, input bit d,
                         input int xc, input int xp, input bit xcw, input bit xpw);
    vec_t v;
    v.cclr = a; v.csm = b; v.pclr = c; v.pc = d;
    v.exp_cnt = xc; v.exp_pcnt = xp; v.exp_cw = xcw; v.exp_pw = xpw;
    vecs.push_back(v);
  endtask

  initial begin
    RN = 1'b0;
    cclr = 1'b0; csm = 1'b0; pclr = 1'b0; pc = 1'b0;
    #3;
    checkOutput(0, 0, 1'b0, 1'b0);
    RN = 1'b1;

    // Count to 300, then reset asynchronously in the middle of a cycle.
    runFree(300);
    #2;
    RN = 1'b0;
    #1;
    ec = 0;
    checkOutput(0, 0, 1'b0, 1'b0);
    @(negedge CK);
    RN = 1'b1;

    // Ten edges to cnt10, then the full wrap back to zero.
    runFree(10);
    checkOne("cnt10_at_10", int'(cnt10), 1);
    runFree(1014);
    checkOne("wrapped_to_0", int'(cnt_q), 0);

    // Stall at 284 for five edges; flag must stay up throughout.
    runFree(284);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, 0, 0);
      checkOutput(284, ep, 1'b0, 1'b0);
    end
    runFree(1);
    checkOne("resume_285", int'(cnt_q), 285);

    // Clear beats stall at 591.
    runFree(306);
    applyStimulus(1, 1, 0, 0);
    ec = 0;
    checkOutput(0, ep, 1'b0, 1'b0);

    // Clear at 1023 must not produce a wrap pulse.
    runFree(1023);
    applyStimulus(1, 0, 0, 0);
    ec = 0;
    checkOutput(0, ep, 1'b0, 1'b0);

    // Phase counter vector table (main counter mostly stalled at 0).
    pushVec(0, 1, 1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 17; k++) begin
      pushVec(0, 1, 0, 1, 0, k, 0, 0);
      pushVec(0, 1, 0, 0, 0, k, 0, 0);
    end
    pushVec(0, 1, 1, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 240; k++)
      pushVec(0, 0, 0, 1, k, k, 0, 0);
    pushVec(0, 1, 1, 1, 240, 0, 0, 0);
    pushVec(0, 1, 0, 0, 240, 0, 0, 0);
    for (int k = 1; k <= 255; k++)
      pushVec(0, 1, 0, 1, 240, k, 0, 0);
    pushVec(0, 1, 0, 1, 240, 0, 0, 1);
    pushVec(1, 1, 0, 0, 0, 0, 0, 0);
    pushVec(0, 0, 0, 1, 1, 1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].cclr, vecs[i].csm, vecs[i].pclr, vecs[i].pc);
      checkOutput(vecs[i].exp_cnt, vecs[i].exp_pcnt, vecs[i].exp_cw, vecs[i].exp_pw);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/video_timing_counters.md
Name: video_timing_counters

Overview:
- Counter/decode stage upstream of the video sync state controller. It produces the terminal-count flags the controller consumes: cnt10, cnt13, cnt21, cnt44, cnt45, cnt261, cnt272, cnt283, cnt284, cnt509, cnt511, cnt567, cnt591, and pcnt6, pcnt12, pcnt17, pcnt27, pcnt241.
- It consumes the controller's clear and count commands: cclr, csm, pclr, pc.
- It holds two counters:
  - main counter (cnt), free-running, for pixel/line timing;
  - phase counter (pcnt), command-stepped, for sub-phases.

Parameters:
- CW, 10, main counter width; must be ≥ 10 so that 591 is representable.
- PW, 8, phase counter width; must be ≥ 8 so that 241 is representable.

Ports:
- CK  in  1  clock; all state updates on the rising edge.
- RN  in  1  asynchronous active-low reset.
- cclr  in  1  synchronous clear of the main counter.
- csm  in  1  main counter hold (stall) when high.
- pclr  in  1  synchronous clear of the phase counter.
- pc  in  1  phase counter increment enable.
- cnt_q  out  CW  main counter value.
- pcnt_q  out  PW  phase counter value.
- cnt10, cnt13, cnt21, cnt44, cnt45, cnt261, cnt272, cnt283, cnt284, cnt509, cnt511, cnt567, cnt591  out  1 each  high while cnt_q equals the named value.
- pcnt6, pcnt12, pcnt17, pcnt27, pcnt241  out  1 each  high while pcnt_q equals the named value.

Behaviour:
- Reset:
  - one clock CK; reset RN is asynchronous, active-low;
  - RN low clears cnt_q and pcnt_q to 0 and all flags to 0, immediately and independent of CK;
  - the first edge after RN is released performs a normal update.
- Main counter next value, in priority order:
  1. cclr=1 → 0;
  2. csm=1 → hold;
  3. otherwise cnt_q+1 modulo 2^CW (1023→0 with CW=10).
- Phase counter next value, in priority order:
  1. pclr=1 → 0;
  2. pc=1 → pcnt_q+1 modulo 2^PW (255→0);
  3. otherwise hold.
- Flags are registered, not combinational from the counter outputs:
  - each flag register loads (next_value == K);
  - so a flag is high exactly in the cycles where the corresponding counter register holds K;
  - latency from command to flag equals latency from command to counter: 1 cycle.
- Simultaneous events:
  - cclr with csm → clear wins;
  - pclr with pc → clear wins;
  - the two counters are fully independent.
- Hold: while csm=1 (or pc=0), the flags keep their values; an asserted flag stays asserted across the stall.
- No flag is high on reset release, because the count is 0 and no decoded value is 0.
- Inputs are synchronous to CK; there is no input synchronisation.
- Reset mid-count discards state; the count restarts from 0.

Optional Feature:
- Macro VTC_WRAP_FLAG_EN.
- When defined, two extra outputs are added:
  - cnt_wrap (1): registered one-cycle pulse when the main counter transitions from 2^CW-1 to 0 by increment; clears do not pulse it;
  - pcnt_wrap (1): the same rule for the phase counter, from 2^PW-1 to 0 by pc.
- Both outputs reset to 0.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package vtc_pkg holds:
  - localparam decode constants CNT_K10..CNT_K591 and PCNT_K6..PCNT_K241;
  - default widths CW_DEF=10 and PW_DEF=8.
- One sub-module, vtc_counter, is instantiated twice:
  - parameters: width W and a decode-value list;
  - function: clear > enable > hold counter with registered equality flags;
  - it also carries the optional wrap pulse.
- The main counter instance uses enable = ~csm; the phase counter instance uses enable = pc.

Test Plan:
- Reset and count: RN low mid-count (cnt_q=300) → cnt_q=0 and all flags 0 immediately. Release with csm=0, cclr=0 → cnt_q=10 and cnt10=1 after 10 edges; cnt10=0 on the next edge.
- Full sweep: free-run 1024 cycles → each cnt flag pulses exactly once, for one cycle, at its value; cnt_q wraps 1023→0. With VTC_WRAP_FLAG_EN, cnt_wrap pulses in the cycle cnt_q=0.
- Stall: hold csm=1 for 5 cycles while cnt_q=284 → cnt284 stays 1 for 6 cycles; cnt_q=285 one edge after csm drops.
- Clear priority: cclr=1 and csm=1 at cnt_q=591 → cnt_q=0 and cnt591=0 next cycle.
- Phase counter: pulse pc 17 times with gaps → pcnt17=1 only after the 17th pc edge. pclr=1 together with pc=1 at pcnt_q=240 → pcnt_q=0 and pcnt241 never asserts.
